// File: rtl/kalman_seq.sv
// kalman_seq: sequencing and state-holding wrapper around the kalman filter core.
//
// Purpose:
//   Holds the filter state (x, P) between iterations.
//   Collects one measurement vector z per iteration from a valid/ready word stream.
//   Launches the filter and latches its x/P results back into the state registers.
//   Streams the new estimate x out one word at a time.
//
// Ports:
//   clk, rst             - single clock; synchronous active-high reset
//   init, x/P_init_flat  - load the initial state (has priority over everything but rst)
//   meas_valid/ready/data - measurement word stream in
//   kf_start, x/P/z_flat - start pulse and operands to the filter
//   kf_done, kf_x/P_out  - completion pulse and results from the filter
//   est_valid/ready/data/last - estimate word stream out
//   busy, iter_count, err - status
//
// Configuration:
//   KALMAN_SEQ_TIMEOUT_EN - adds a WAIT watchdog of TIMEOUT cycles and a sticky err flag.
//
// State table:
//   state     | meaning
//   S_UNINIT  | no valid state loaded, waits for init
//   S_COLLECT | accepts measurement words into z
//   S_RUN     | one-cycle kf_start pulse
//   S_WAIT    | waits for kf_done (optionally bounded by the watchdog)
//   S_EMIT    | streams x[0..N_STATE-1] to the estimate port

module kalman_seq #(
  parameter int WIDTH   = 32,
  parameter int N_STATE = 6,
  parameter int N_MEAS  = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               init,
  input  logic [N_STATE*WIDTH-1:0]           x_init_flat,
  input  logic [N_STATE*N_STATE*WIDTH-1:0]   P_init_flat,
  input  logic                               meas_valid,
  input  logic [WIDTH-1:0]                   meas_data,
  output logic                               meas_ready,
  output logic                               kf_start,
  output logic [N_STATE*WIDTH-1:0]           x_flat,
  output logic [N_STATE*N_STATE*WIDTH-1:0]   P_flat,
  output logic [N_MEAS*WIDTH-1:0]            z_flat,
  input  logic                               kf_done,
  input  logic [N_STATE*WIDTH-1:0]           kf_x_out,
  input  logic [N_STATE*N_STATE*WIDTH-1:0]   kf_P_out,
  output logic                               est_valid,
  output logic [WIDTH-1:0]                   est_data,
  output logic                               est_last,
  input  logic                               est_ready,
  output logic                               busy,
  output logic [15:0]                        iter_count,
  output logic                               err
);

  localparam int IW = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;
  localparam int EW = (N_STATE > 1) ? $clog2(N_STATE) : 1;

  typedef enum logic [2:0] {
    S_UNINIT,
    S_COLLECT,
    S_RUN,
    S_WAIT,
    S_EMIT
  } state_t;

  state_t                             state_q, state_d;
  logic [N_STATE*WIDTH-1:0]           x_q;
  logic [N_STATE*N_STATE*WIDTH-1:0]   P_q;
  logic [N_MEAS*WIDTH-1:0]            z_q;
  logic [IW-1:0]                      idx_q;
  logic [EW-1:0]                      eidx_q;
  logic [15:0]                        iter_q;
  logic                               meas_last;
  logic                               emit_last;
  logic                               wd_expired;

  assign meas_last = (idx_q == IW'(N_MEAS - 1));
  assign emit_last = (eidx_q == EW'(N_STATE - 1));

  assign x_flat     = x_q;
  assign P_flat     = P_q;
  assign z_flat     = z_q;
  assign iter_count = iter_q;
  // Gated so the port reads zero whenever no word is being offered.
  assign est_data   = est_valid ? x_q[WIDTH*int'(eidx_q) +: WIDTH] : '0;

`ifdef KALMAN_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_q;
  logic          err_q;

  assign wd_expired = (wd_q == '0);
  assign err        = err_q;

  // Down-counter loaded in RUN so that WAIT lasts at most TIMEOUT cycles;
  // a kf_done on the terminal cycle still wins over the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else if (init) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else if (state_q == S_RUN) begin
      wd_q <= TW'(TIMEOUT - 1);
    end else if (state_q == S_WAIT && !kf_done) begin
      if (wd_expired) err_q <= 1'b1;
      else            wd_q  <= wd_q - 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_UNINIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    meas_ready = 1'b0;
    kf_start   = 1'b0;
    est_valid  = 1'b0;
    est_last   = 1'b0;
    busy       = 1'b0;
    case (state_q)
      S_UNINIT: ;
      S_COLLECT: begin
        meas_ready = 1'b1;
        if (meas_valid && meas_last) state_d = S_RUN;
      end
      S_RUN: begin
        kf_start = 1'b1;
        busy     = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (kf_done)         state_d = S_EMIT;
        else if (wd_expired) state_d = S_COLLECT;
      end
      S_EMIT: begin
        busy      = 1'b1;
        est_valid = 1'b1;
        est_last  = emit_last;
        if (est_ready && emit_last) state_d = S_COLLECT;
      end
      default: state_d = S_UNINIT;
    endcase
    if (init) state_d = S_COLLECT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      P_q    <= '0;
      z_q    <= '0;
      idx_q  <= '0;
      eidx_q <= '0;
      iter_q <= '0;
    end else if (init) begin
      x_q    <= x_init_flat;
      P_q    <= P_init_flat;
      z_q    <= '0;
      idx_q  <= '0;
      eidx_q <= '0;
      iter_q <= '0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (meas_valid) begin
            z_q[WIDTH*int'(idx_q) +: WIDTH] <= meas_data;
            idx_q <= meas_last ? '0 : idx_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (kf_done) begin
            x_q    <= kf_x_out;
            P_q    <= kf_P_out;
            iter_q <= iter_q + 16'd1;
            eidx_q <= '0;
          end
        end
        S_EMIT: begin
          if (est_ready) eidx_q <= emit_last ? '0 : eidx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kalman_seq.sv
// tb_kalman_seq: directed self-checking bench for kalman_seq.
// The filter core is stood in for by the stimulus itself (kf_done/kf_x_out
// driven from the sequence below). Inputs change and outputs are sampled on
// the falling edge.

module tb_kalman_seq;

  localparam int WIDTH = 32;
  localparam int NS    = 6;
  localparam int NM    = 4;
  localparam int XW    = NS * WIDTH;
  localparam int PW    = NS * NS * WIDTH;
  localparam int ZW    = NM * WIDTH;

  logic            clk = 1'b0;
  logic            rst, init, meas_valid, meas_ready, kf_start, kf_done;
  logic            est_valid, est_last, est_ready, busy, err;
  logic [WIDTH-1:0] meas_data, est_data;
  logic [XW-1:0]   x_init_flat, x_flat, kf_x_out;
  logic [PW-1:0]   P_init_flat, P_flat, kf_P_out;
  logic [ZW-1:0]   z_flat;
  logic [15:0]     iter_count;

  logic [XW-1:0]   xres1, xres2, xinit2;
  logic [PW-1:0]   pres1;

  int errors = 0;
  int checks = 0;
  int starts, widx, lasts, cyc;

  kalman_seq dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .x_init_flat(x_init_flat),
    .P_init_flat(P_init_flat),
    .meas_valid (meas_valid),
    .meas_data  (meas_data),
    .meas_ready (meas_ready),
    .kf_start   (kf_start),
    .x_flat     (x_flat),
    .P_flat     (P_flat),
    .z_flat     (z_flat),
    .kf_done    (kf_done),
    .kf_x_out   (kf_x_out),
    .kf_P_out   (kf_P_out),
    .est_valid  (est_valid),
    .est_data   (est_data),
    .est_last   (est_last),
    .est_ready  (est_ready),
    .busy       (busy),
    .iter_count (iter_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    chk("collect_ready", 64'(meas_ready), 64'd1);
    meas_valid = 1'b1;
    meas_data  = d;
    step();
    meas_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; meas_valid = 1'b0; meas_data = '0;
    kf_done = 1'b0; kf_x_out = '0; kf_P_out = '0; est_ready = 1'b0;
    for (int i = 0; i < NS; i++) begin
      x_init_flat[WIDTH*i +: WIDTH] = WIDTH'(i << 12);
      xres1[WIDTH*i +: WIDTH]       = WIDTH'(32'h100 * (i + 1));
      xres2[WIDTH*i +: WIDTH]       = WIDTH'(32'h1100 * (i + 1));
      xinit2[WIDTH*i +: WIDTH]      = WIDTH'(32'h7000 + i);
    end
    for (int k = 0; k < NS * NS; k++) begin
      P_init_flat[WIDTH*k +: WIDTH] = (k % (NS + 1) == 0) ? 32'h1000 : 32'h0;
      pres1[WIDTH*k +: WIDTH]       = WIDTH'(k + 1);
    end

    // Reset state
    repeat (3) step();
    chk("rst_meas_ready", 64'(meas_ready), 64'd0);
    chk("rst_kf_start", 64'(kf_start), 64'd0);
    chk("rst_est_valid", 64'(est_valid), 64'd0);
    chk("rst_est_data", 64'(est_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_iter", 64'(iter_count), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chkv("rst_x", PW'(x_flat), '0);
    chkv("rst_P", P_flat, '0);
    chkv("rst_z", PW'(z_flat), '0);

    // Idle in UNINIT with meas_valid high
    rst = 1'b0;
    meas_valid = 1'b1;
    meas_data  = 32'h5555;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_meas_ready", 64'(meas_ready), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
    end
    meas_valid = 1'b0;
    chkv("idle_z", PW'(z_flat), '0);

    // Full iteration
    init = 1'b1;
    step();
    init = 1'b0;
    chkv("init_x", PW'(x_flat), PW'(x_init_flat));
    chkv("init_P", P_flat, P_init_flat);
    chk("init_iter", 64'(iter_count), 64'd0);
    send(32'h1000); send(32'h2000); send(32'h3000); send(32'h4000);
    chk("run_start", 64'(kf_start), 64'd1);
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_meas_ready", 64'(meas_ready), 64'd0);
    chkv("run_z", PW'(z_flat), PW'({32'h4000, 32'h3000, 32'h2000, 32'h1000}));
    starts = 1;
    for (int c = 0; c < 19; c++) begin
      step();
      if (kf_start) starts++;
    end
    chk("one_start", 64'(starts), 64'd1);
    chk("wait_meas_ready", 64'(meas_ready), 64'd0);
    chkv("wait_x_stable", PW'(x_flat), PW'(x_init_flat));
    kf_done = 1'b1; kf_x_out = xres1; kf_P_out = pres1;
    step();
    kf_done = 1'b0;
    est_ready = 1'b1;
    for (int i = 0; i < NS; i++) begin
      chk("emit_valid", 64'(est_valid), 64'd1);
      chk("emit_data", 64'(est_data), 64'(32'h100 * (i + 1)));
      chk("emit_last", 64'(est_last), 64'(i == NS - 1));
      step();
    end
    est_ready = 1'b0;
    chk("post_emit_ready", 64'(meas_ready), 64'd1);
    chk("post_emit_valid", 64'(est_valid), 64'd0);
    chk("iter_one", 64'(iter_count), 64'd1);
    chkv("next_x", PW'(x_flat), PW'(xres1));
    chkv("next_P", P_flat, pres1);

    // Spurious done in COLLECT
    kf_done = 1'b1; kf_x_out = xres2;
    step();
    kf_done = 1'b0;
    chk("spur_ready", 64'(meas_ready), 64'd1);
    chk("spur_busy", 64'(busy), 64'd0);
    chk("spur_iter", 64'(iter_count), 64'd1);
    chkv("spur_x", PW'(x_flat), PW'(xres1));

    // Backpressure iteration
    send(32'h5000); send(32'h6000); send(32'h7000); send(32'h8000);
    chk("bp_start", 64'(kf_start), 64'd1);
    repeat (4) step();
    kf_done = 1'b1;
    step();
    kf_done = 1'b0;
    widx = 0; lasts = 0; cyc = 0;
    while (widx < NS && cyc < 40) begin
      est_ready = cyc[0];
      chk("bp_valid", 64'(est_valid), 64'd1);
      chk("bp_data", 64'(est_data), 64'(xres2[WIDTH*widx +: WIDTH]));
      chk("bp_last", 64'(est_last), 64'(widx == NS - 1));
      if (est_ready && est_last) lasts++;
      if (est_ready) widx++;
      cyc++;
      step();
    end
    est_ready = 1'b0;
    chk("bp_words", 64'(widx), 64'(NS));
    chk("bp_last_once", 64'(lasts), 64'd1);
    chk("bp_ready_after", 64'(meas_ready), 64'd1);
    chk("bp_iter", 64'(iter_count), 64'd2);

    // init after two measurement words
    send(32'hAAA); send(32'hBBB);
    init = 1'b1;
    step();
    init = 1'b0;
    chkv("mid_init_z", PW'(z_flat), '0);
    chk("mid_init_iter", 64'(iter_count), 64'd0);
    // init together with the 4th word
    send(32'h11); send(32'h22); send(32'h33);
    meas_valid = 1'b1; meas_data = 32'h44; init = 1'b1;
    step();
    meas_valid = 1'b0; init = 1'b0;
    chk("init4_no_start", 64'(kf_start), 64'd0);
    chk("init4_ready", 64'(meas_ready), 64'd1);
    chkv("init4_z", PW'(z_flat), '0);
    step();
    chk("init4_no_start_later", 64'(kf_start), 64'd0);
    send(32'h11); send(32'h22); send(32'h33); send(32'h44);
    chkv("restart_z", PW'(z_flat), PW'({32'h44, 32'h33, 32'h22, 32'h11}));
    chk("restart_start", 64'(kf_start), 64'd1);
    // init during WAIT, coincident with kf_done
    repeat (3) step();
    x_init_flat = xinit2;
    init = 1'b1; kf_done = 1'b1; kf_x_out = xres1;
    step();
    init = 1'b0; kf_done = 1'b0;
    chkv("waitinit_x", PW'(x_flat), PW'(xinit2));
    chkv("waitinit_P", P_flat, P_init_flat);
    chk("waitinit_iter", 64'(iter_count), 64'd0);
    chk("waitinit_est_valid", 64'(est_valid), 64'd0);
    chk("waitinit_ready", 64'(meas_ready), 64'd1);

`ifdef KALMAN_SEQ_TIMEOUT_EN
    // Watchdog: no kf_done
    send(32'h1); send(32'h2); send(32'h3); send(32'h4);
    step();
    cyc = 0; lasts = 0;
    while (!meas_ready && cyc < 4300) begin
      if (est_valid) lasts++;
      cyc++;
      step();
    end
    chk("to_ready", 64'(meas_ready), 64'd1);
    chk("to_err", 64'(err), 64'd1);
    chk("to_no_est", 64'(lasts), 64'd0);
    chk("to_iter", 64'(iter_count), 64'd0);
    chkv("to_x", PW'(x_flat), PW'(xinit2));
    init = 1'b1;
    step();
    init = 1'b0;
    chk("to_err_clear", 64'(err), 64'd0);
`else
    chk("no_timeout_err", 64'(err), 64'd0);
`endif

    // Reset mid-operation
    send(32'h9); send(32'hA);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ready", 64'(meas_ready), 64'd0);
    chk("midrst_iter", 64'(iter_count), 64'd0);
    chkv("midrst_z", PW'(z_flat), '0);
    chkv("midrst_x", PW'(x_flat), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kalman_seq.md
# kalman_seq

Sequencing and state-holding wrapper around the `kalman` top level. It stores the filter state between iterations: state estimate x and covariance P. It collects one measurement vector z per iteration from a valid/ready word stream and launches one predict/gain/update pass. It then writes the filter's x and P results back into its state registers and streams the new estimate out word by word. It sits directly around `kalman`: it drives `start`, `x_flat`, `P_flat` and `z_flat`, and consumes `done`, `x_out` and `P_out`.

## Interface
- Parameters:
- `WIDTH`, 32, word width, Q20.12 signed.
- `N_STATE`, 6, state vector length.
- `N_MEAS`, 4, measurement vector length.
- `TIMEOUT`, 4096, watchdog limit in cycles. Used only when `KALMAN_SEQ_TIMEOUT_EN` is defined.
- Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `init`  in  1  pulse; loads the initial state.
- `x_init_flat`  in  N_STATE*WIDTH  initial x.
- `P_init_flat`  in  N_STATE*N_STATE*WIDTH  initial P.
- `meas_valid`  in  1  measurement word valid.
- `meas_data`  in  WIDTH  measurement word.
- `meas_ready`  out  1  measurement word accepted this cycle when high together with `meas_valid`.
- `kf_start`  out  1  one-cycle start pulse to `kalman`.
- `x_flat`  out  N_STATE*WIDTH  state x driven to the filter.
- `P_flat`  out  N_STATE*N_STATE*WIDTH  state P driven to the filter.
- `z_flat`  out  N_MEAS*WIDTH  assembled measurement.
- `kf_done`  in  1  one-cycle completion pulse from `kalman`.
- `kf_x_out`  in  N_STATE*WIDTH  updated x from the filter.
- `kf_P_out`  in  N_STATE*N_STATE*WIDTH  updated P from the filter.
- `est_valid`  out  1  estimate word valid.
- `est_data`  out  WIDTH  estimate word.
- `est_last`  out  1  high on the final estimate word.
- `est_ready`  in  1  downstream accepts the estimate word.
- `busy`  out  1  high in RUN, WAIT and EMIT.
- `iter_count`  out  16  completed iterations since the last `init`.
- `err`  out  1  sticky timeout flag.

## Operation
- Packing: element i occupies bits `[WIDTH*i +: WIDTH]`. P is row-major, element (r,c) is index r*N_STATE+c. No arithmetic is performed; words pass through bit-exact.
- FSM states are UNINIT, COLLECT, RUN, WAIT and EMIT.
- UNINIT: `meas_ready`=0. `init` → load x and P from `x_init_flat` and `P_init_flat`, clear `z_flat` and the word index, set `iter_count`=0, go to COLLECT.
- COLLECT: `meas_ready`=1.
  - Each accepted word is written to z[idx] and idx increments.
  - When word N_MEAS-1 is accepted, idx returns to 0 and the FSM goes to RUN.
- RUN: lasts exactly one cycle with `kf_start`=1, then goes to WAIT.
- WAIT: `meas_ready`=0.
  - On `kf_done`=1, register `kf_x_out` into x and `kf_P_out` into P on that edge, increment `iter_count` (wraps at 16 bits), and go to EMIT.
- EMIT: present x[0..N_STATE-1] in order, using the newly latched x.
  - `est_data`, `est_last` and `est_valid` stay stable until accepted (`est_valid`&`est_ready`).
  - After word N_STATE-1 is accepted, go to COLLECT.
- `init` has priority in every state other than reset. It performs the UNINIT load and goes to COLLECT:
  - a partial z is discarded;
  - a pending filter result is ignored;
  - EMIT is abandoned, with `est_valid` low the next cycle.
- `kf_done` outside WAIT is ignored.
- `x_flat`, `P_flat` and `z_flat` change only on `init`, on a WAIT latch, or on a COLLECT write. They are therefore stable throughout RUN and WAIT.

## Timing
- Reset: all outputs are 0; FSM is in UNINIT; x, P, z, idx and `iter_count` are 0; `err` is 0.
- The 4th measurement acceptance at edge n gives `kf_start`=1 in cycle n+1 and WAIT from n+2.
- `kf_done` sampled at edge m gives `est_valid`=1 from cycle m+1.
- With `est_ready` held high, EMIT takes exactly N_STATE cycles, and `meas_ready`=1 in the cycle after the last word.
- `est_ready`=0 stalls EMIT indefinitely with no loss of data.
- `init` in the same cycle as the 4th measurement: `init` wins, the FSM goes to COLLECT with idx=0, and no `kf_start` is issued.
- `init` in the same cycle as `kf_done`: `init` wins, and x and P take the init values.
- Reset asserted mid-operation returns the block to the reset state on the next edge.

## Configuration
- `KALMAN_SEQ_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT.
  - If TIMEOUT cycles pass without `kf_done`, the FSM goes to COLLECT and sets `err`=1.
  - x, P and `iter_count` are unchanged and no estimate is emitted.
  - `err` clears only on `rst` or `init`.
- `KALMAN_SEQ_TIMEOUT_EN` undefined: WAIT has no limit, `err` is tied to 0, and no counter logic is present.

## Test plan
- Reset then idle: all outputs 0 and `meas_ready`=0 for 10 cycles; `meas_valid`=1 is ignored.
- Full iteration:
  - Stimulus: `init` with x[i]=i<<12 and P=identity<<12; then z words 0x1000, 0x2000, 0x3000, 0x4000; the filter model returns `kf_x_out`[i]=0x100*(i+1) after 20 cycles.
  - Required: `z_flat`=0x00004000_00003000_00002000_00001000; exactly one `kf_start` pulse.
  - Required: `est_data` sequence 0x100 to 0x600 with `est_last` on the 6th word; `iter_count`=1; the next iteration's `x_flat` equals `kf_x_out`.
- Backpressure: `est_ready` toggles every other cycle → all 6 words are delivered in order, each held stable while stalled, and `est_last` appears once.
- Mid-operation `init`:
  - `init` after 2 measurement words → idx restarts; 4 further words produce z made of those 4 words only.
  - `init` during WAIT → `kf_done` is ignored and x equals `x_init_flat`.
- Spurious done: `kf_done` pulsed in COLLECT → no state change, and `iter_count` stays unchanged.
- Timeout, with the macro defined: no `kf_done` for 4096 cycles → `err`=1, FSM back in COLLECT with `meas_ready`=1, x unchanged, and `init` clears `err`.
